// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared CPU definitions for the hazard controller.
//               - multiply/divide tracker state encoding
//               - default multiply/divide latencies
//               - countdown width
//               - operand-match helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    // Countdown width. Six bits holds the longest latency, a 32-cycle divide.
    localparam int MD_CNT_W         = 6;
    localparam int MUL_CYCLES_DEF   = 3;
    localparam int DIV_CYCLES_DEF   = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    // True when the ID instruction reads a register the producer writes.
    // Register 0 is hard-wired, so a match on it is never a hazard.
    function automatic logic src_match(
        input logic       uses_rs,
        input logic [4:0] rs,
        input logic       uses_rt,
        input logic [4:0] rt,
        input logic [4:0] wreg
    );
        return (wreg != 5'd0) &&
               ((uses_rs && (rs == wreg)) || (uses_rt && (rt == wreg)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline <-> hazard controller signal bundle.
//               master : pipeline side (drives stage info, receives stalls)
//               slave  : hazard controller side
// Ports       : ID source regs and flags, EX/MEM producer info,
//               mul/div issue, stall outputs, md_busy/md_done, stall_cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;

    logic [4:0]  id_Rs;
    logic [4:0]  id_Rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_branch;
    logic        id_reads_hilo;
    logic        id_md_op;
    logic        ex_MemRead;
    logic        ex_RegWrite;
    logic [4:0]  ex_wreg;
    logic        mem_MemRead;
    logic [4:0]  mem_wreg;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    modport master (
        output id_Rs, id_Rt, id_uses_rs, id_uses_rt, id_branch,
               id_reads_hilo, id_md_op, ex_MemRead, ex_RegWrite, ex_wreg,
               mem_MemRead, mem_wreg, ex_md_start, ex_md_is_div,
        input  stall_pc, stall_if_id, stall_id_ex, md_busy, md_done,
               stall_cycles
    );

    modport slave (
        input  id_Rs, id_Rt, id_uses_rs, id_uses_rt, id_branch,
               id_reads_hilo, id_md_op, ex_MemRead, ex_RegWrite, ex_wreg,
               mem_MemRead, mem_wreg, ex_md_start, ex_md_is_div,
        output stall_pc, stall_if_id, stall_id_ex, md_busy, md_done,
               stall_cycles
    );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_md_tracker.sv
// ============================================================================
// Module      : md_tracker
// Description : Tracks how long a multiply/divide keeps HI/LO occupied.
//               - a start loads the latency into a down-counter
//               - a start while busy restarts the count (old op discarded)
//               - md_done pulses in the first idle cycle after a countdown
// Ports       : clk, rst (sync, active-low), md_start_i, md_is_div_i,
//               md_busy_o, md_done_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic md_start_i,
    input  wire logic md_is_div_i,
    output logic      md_busy_o,
    output logic      md_done_o
);

    localparam logic [MD_CNT_W-1:0] c_MUL_CNT = MD_CNT_W'(MUL_CYCLES);
    localparam logic [MD_CNT_W-1:0] c_DIV_CNT = MD_CNT_W'(DIV_CYCLES);
    localparam logic [MD_CNT_W-1:0] c_ONE     = MD_CNT_W'(1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q,   cnt_d;
    logic                done_q,  done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (md_start_i) begin
            // Start wins over countdown, so a restart on the last busy
            // cycle never produces a done pulse for the discarded op.
            state_d = md_is_div_i ? MD_DIV : MD_MUL;
            cnt_d   = md_is_div_i ? c_DIV_CNT : c_MUL_CNT;
        end else if (state_q != MD_IDLE) begin
            if (cnt_q == c_ONE) begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q - c_ONE;
            end
        end
    end

    // Forced low during reset so the pipeline never sees stale status.
    assign md_busy_o = rst && (state_q != MD_IDLE);
    assign md_done_o = rst && done_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller.
//               - load-use interlock
//               - branch-in-ID interlock on EX writes and MEM loads
//               - HI/LO interlock while a multiply/divide is outstanding
//               - saturating count of bubble cycles
// Ports       : clk, rst (sync, active-low), bus (hazard_ctrl_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hazard_ctrl_if.slave bus
);

    logic        md_busy_w;
    logic        md_done_w;
    logic        ex_hit_w;
    logic        mem_hit_w;
    logic        load_use_w;
    logic        branch_ex_w;
    logic        branch_mem_w;
    logic        hilo_w;
    logic        bubble_w;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    md_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_tracker (
        .clk         (clk),
        .rst         (rst),
        .md_start_i  (bus.ex_md_start),
        .md_is_div_i (bus.ex_md_is_div),
        .md_busy_o   (md_busy_w),
        .md_done_o   (md_done_w)
    );

    assign ex_hit_w  = src_match(bus.id_uses_rs, bus.id_Rs,
                                 bus.id_uses_rt, bus.id_Rt, bus.ex_wreg);
    assign mem_hit_w = src_match(bus.id_uses_rs, bus.id_Rs,
                                 bus.id_uses_rt, bus.id_Rt, bus.mem_wreg);

    assign load_use_w   = bus.ex_MemRead && ex_hit_w;
    // Branches compare in ID, so they also wait on ALU results in EX and
    // on load data still in MEM: a load followed by a branch costs two bubbles.
    assign branch_ex_w  = bus.id_branch && bus.ex_RegWrite && ex_hit_w;
    assign branch_mem_w = bus.id_branch && bus.mem_MemRead && mem_hit_w;
    // An op issuing this cycle is not yet visible in md_busy, hence ex_md_start.
    assign hilo_w       = (bus.id_reads_hilo || bus.id_md_op) &&
                          (md_busy_w || bus.ex_md_start);

    assign bubble_w = rst &&
                      (load_use_w || branch_ex_w || branch_mem_w || hilo_w);

    assign stall_cycles_d = (bubble_w && (stall_cycles_q != 32'hFFFF_FFFF))
                          ? stall_cycles_q + 32'd1 : stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_pc     = bubble_w;
    assign bus.stall_if_id  = bubble_w;
    assign bus.stall_id_ex  = bubble_w;
    assign bus.md_busy      = md_busy_w;
    assign bus.md_done      = md_done_w;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire
